// File: rtl/seq_detect_sched.sv
// seq_detect_sched: round-robin sharing of one serial pattern detector among N_CH bit streams.
// Define SDS_TIMEOUT_EN to add a stall watchdog that aborts a burst after TO_CYC idle cycles.
module seq_detect_sched #(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 8,
  parameter int DET_LAT = 1,
  parameter int TO_CYC  = 16,
  localparam int CH_W   = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   req,
  input  logic [N_CH-1:0]   valid,
  input  logic [N_CH-1:0]   bit_in,
  input  logic [N_CH-1:0]   last,
  output logic [N_CH-1:0]   gnt,
  output logic              det_clr,
  output logic              det_en,
  output logic              det_in,
  input  logic              det_detect,
  output logic              done,
  output logic [CH_W-1:0]   done_ch,
  output logic [CNT_W-1:0]  done_cnt,
  output logic              done_abort,
  output logic              busy
);
  localparam int LAT_W = $clog2(DET_LAT + 1);
  typedef enum logic [2:0] {IDLE, CLR, STREAM, DRAIN, REPORT} state_t;
  state_t state, state_n;
  logic [CH_W-1:0] ch, ptr, pick;
  logic [CNT_W-1:0] cnt;
  logic [LAT_W-1:0] lat;
  logic abort, v, l, stall;
  assign v = valid[ch];
  assign l = valid[ch] & last[ch];
  assign busy = state != IDLE;
`ifdef SDS_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYC + 1);
  logic [TO_W-1:0] idle_cyc;
  assign stall = !v && idle_cyc == TO_W'(TO_CYC - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) idle_cyc <= '0;
    else idle_cyc <= (state == STREAM && !v) ? idle_cyc + 1'b1 : '0;
`else
  logic unused_to;
  assign unused_to = TO_CYC != 0;
  assign stall = 1'b0;
`endif
  // later iterations override, so the lowest offset from ptr wins
  always_comb begin
    pick = ptr;
    for (int i = N_CH - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N_CH]) pick = CH_W'((int'(ptr) + i) % N_CH);
  end
  always_comb begin
    state_n = state;
    gnt = '0;
    det_clr = 1'b0;
    det_en = 1'b0;
    det_in = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: state_n = |req ? CLR : IDLE;
      CLR: begin
        gnt = N_CH'(1) << ch;
        det_clr = 1'b1;
        state_n = STREAM;
      end
      STREAM: begin
        gnt = N_CH'(1) << ch;
        det_en = v;
        det_in = bit_in[ch];
        state_n = (l || !req[ch] || stall) ? DRAIN : STREAM;
      end
      DRAIN: state_n = lat == LAT_W'(DET_LAT - 1) ? REPORT : DRAIN;
      REPORT: begin
        done = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    done_ch = done ? ch : '0;
    done_cnt = done ? cnt : '0;
    done_abort = done & abort;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      ch <= '0;
      ptr <= '0;
      cnt <= '0;
      lat <= '0;
      abort <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE) ch <= pick;
      if (state == CLR) begin
        cnt <= '0;
        abort <= 1'b0;
      end else if ((state == STREAM || state == DRAIN) && det_detect && cnt != '1) cnt <= cnt + 1'b1;
      if (state == STREAM && state_n == DRAIN) abort <= !l;
      lat <= state == DRAIN ? lat + 1'b1 : '0;
      if (state == REPORT) ptr <= ch == CH_W'(N_CH - 1) ? '0 : ch + 1'b1;
    end
endmodule

// File: tb/tb_seq_detect_sched.sv
// tb_seq_detect_sched: random bursts against a queue-based scoreboard; a 3-ones detector
// (registered, one cycle latency, history cleared by det_clr) stands in for the shared detector.
module tb_seq_detect_sched;
  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] req = '0, valid = '0, bit_in = '0, last = '0, gnt;
  logic det_clr, det_en, det_in, det_detect, done, done_abort, busy;
  logic [1:0] done_ch;
  logic [7:0] done_cnt;
  logic [1:0] hist;
  typedef struct {int ch; int cnt; bit ab;} exp_t;
  exp_t q[$];
  exp_t e;
  bit pat[$];
  bit bits[$];
  int n_chk = 0, n_err = 0, ptr = 0;
  int gap_pct = 0, abort_at = -1, stall_at = -1, stall_n = 0;
  bit drop_last = 0;

  seq_detect_sched dut (
    .clk(clk), .rst(rst), .req(req), .valid(valid), .bit_in(bit_in), .last(last),
    .gnt(gnt), .det_clr(det_clr), .det_en(det_en), .det_in(det_in), .det_detect(det_detect),
    .done(done), .done_ch(done_ch), .done_cnt(done_cnt), .done_abort(done_abort), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst)
    if (!rst) begin hist <= '0; det_detect <= 1'b0; end
    else if (det_clr) begin hist <= '0; det_detect <= 1'b0; end
    else if (det_en) begin hist <= {hist[0], det_in}; det_detect <= hist[1] & hist[0] & det_in; end
    else det_detect <= 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  endtask

  function automatic int rr_pick(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[(ptr + i) % 4]) return (ptr + i) % 4;
    return -1;
  endfunction

  // overlapping count of 111 windows in the consumed bits, saturated at 255
  function automatic int exp_cnt();
    int run = 0, c = 0;
    foreach (bits[i]) begin
      run = bits[i] ? run + 1 : 0;
      if (run >= 3) c++;
    end
    return c > 255 ? 255 : c;
  endfunction

  always @(negedge clk)
    if (rst && done) begin
      if (q.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        e = q.pop_front();
        chk("done_ch", done_ch, e.ch);
        chk("done_cnt", done_cnt, e.cnt);
        chk("done_abort", done_abort, e.ab);
      end
    end

  task automatic burst(input logic [3:0] mask);
    int ch, k, cyc, meas, w, st;
    bit v, ab, fin;
    @(negedge clk);
    req = mask; valid = '0; last = '0;
    ch = rr_pick(mask);
    w = 0;
    do begin @(negedge clk); w++; end while (!det_clr && w < 4);
    chk("clr_pulse", det_clr, 1);
    chk("gnt_rr", gnt, 1 << ch);
    chk("busy_clr", busy, 1);
    if (!det_clr) finish_run();
    meas = (gnt == (4'b1 << ch)) ? 1 : 0;
    bits.delete();
    k = 0; cyc = 0; ab = 0; fin = 0; st = stall_n;
    while (!fin) begin
      @(negedge clk);
      meas += (gnt == (4'b1 << ch)) ? 1 : 0;
      cyc++;
      for (int j = 0; j < 4; j++)
        if (j != ch) begin valid[j] = 1'($urandom); bit_in[j] = 1'($urandom); last[j] = 1'($urandom); end
      bit_in[ch] = (k < pat.size()) ? pat[k] : 1'($urandom);
      if (k == abort_at) begin
        req[ch] = 1'b0; v = 1'($urandom); last[ch] = 1'b0; ab = 1; fin = 1;
      end else if (k == stall_at && st > 0) begin
        v = 0; st--; last[ch] = 1'($urandom);
      end else begin
        v = $urandom_range(99) >= gap_pct;
        last[ch] = v && k == pat.size() - 1;
        fin = last[ch];
        if (fin && drop_last) req[ch] = 1'b0;
      end
      valid[ch] = v;
      if (v) begin bits.push_back(bit_in[ch]); k++; end
      #1;
      chk("det_en", det_en, v);
      if (v) chk("det_in", det_in, bit_in[ch]);
      if (cyc > 5000) begin chk("stream_timeout", cyc, 0); finish_run(); end
    end
    @(negedge clk);
    chk("gnt_drain", gnt, 0);
    chk("det_en_drain", det_en, 0);
    req = '0; valid = '0; last = '0;
    q.push_back('{ch, exp_cnt(), ab});
    chk("gnt_cycles", meas, cyc + 1);
    ptr = (ch + 1) % 4;
    w = 0;
    while (busy && w < 10) begin @(negedge clk); w++; end
    chk("idle_after", busy, 0);
  endtask

  task automatic set_pat(input int n, input int ones_pct);
    pat.delete();
    for (int i = 0; i < n; i++) pat.push_back($urandom_range(99) < ones_pct);
  endtask

  initial begin
    #500000;
    chk("global_timeout", 1, 0);
    finish_run();
  end

  initial begin
    req = 4'b1111;
    repeat (3) @(negedge clk);
    chk("reset_outs", {gnt, det_clr, det_en, det_in, done, done_ch, done_cnt, done_abort, busy}, 0);
    req = '0;
    rst = 1'b1;
    // round robin from pointer 0: ch0 then ch2, then pointer 3 serves ch3 first
    set_pat(4, 70); burst(4'b0101);
    set_pat(4, 70); burst(4'b0101);
    chk("ptr_after_ch2", ptr, 3);
    set_pat(3, 70); burst(4'b1111);
    pat = '{1, 1, 1, 1, 0}; burst(4'b0001);
    // history must not leak between bursts
    pat = '{0, 1, 1}; burst(4'b0010);
    pat = '{1, 0}; burst(4'b0100);
    pat.delete(); repeat (10) pat.push_back(1'b1);
    gap_pct = 30; burst(4'b1000);
    pat.delete(); repeat (300) pat.push_back(1'b1);
    burst(4'b1000);
    gap_pct = 0;
    set_pat(6, 80); abort_at = 2; burst(4'b0001);
    abort_at = -1; drop_last = 1; set_pat(5, 80); burst(4'b0010);
    drop_last = 0;
`ifndef SDS_TIMEOUT_EN
    set_pat(4, 100); stall_at = 2; stall_n = 20; burst(4'b0100);
    stall_at = -1; stall_n = 0;
`endif
    for (int n = 0; n < 40; n++) begin
      gap_pct = 20;
      set_pat($urandom_range(1, 12), 75);
      abort_at = ($urandom_range(3) == 0) ? $urandom_range(pat.size() - 1) : -1;
      drop_last = $urandom_range(3) == 0;
      burst(4'($urandom_range(1, 15)));
    end
    abort_at = -1; drop_last = 0; gap_pct = 0;
    // asynchronous reset in the middle of a stream
    @(negedge clk); req = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    chk("gnt_pre_rst", gnt, 2);
    valid[1] = 1'b1; bit_in[1] = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("rst_mid_outs", {gnt, det_clr, det_en, det_in, done, done_ch, done_cnt, done_abort, busy}, 0);
    req = '0; valid = '0; bit_in = '0;
    @(negedge clk); rst = 1'b1;
    ptr = 0;
    set_pat(5, 70); burst(4'b1111);
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    finish_run();
  end
endmodule
